// File: rtl/npu_pkg.sv
// Shared NPU types, default widths and the quantize/activate helpers.
package npu_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned WIDE_WIDTH = 64;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [WIDE_WIDTH-1:0] wide_t;

  localparam data_t DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam data_t DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Arithmetic right shift then saturate to a signed dw-bit range.
  // Works at a wide width so any accumulator/data width pairing can share it;
  // the caller truncates the result to its data width.
  function automatic wide_t sat_shift(input wide_t sum, input int unsigned shift,
                                      input int unsigned dw);
    wide_t s;
    wide_t hi;
    wide_t lo;
    s  = sum >>> shift;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dw - 1));
    if (s > hi)      sat_shift = hi;
    else if (s < lo) sat_shift = lo;
    else             sat_shift = s;
  endfunction

  // Rectified linear activation.
  function automatic wide_t relu(input wide_t v);
    relu = (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/mac_tree.sv
// Combinational N-way signed multiply and sum producing the dot product.
module mac_tree #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic signed [DATA_WIDTH-1:0] x [N],
  input  logic signed [DATA_WIDTH-1:0] w [N],
  output logic signed [ACC_WIDTH-1:0]  dp
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] prod [N];

  // Full-precision products, operands sign-extended before multiplying.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = PW'(x[i]) * PW'(w[i]);
    end
  end

  // Sum of sign-extended products; the width rule guarantees no overflow.
  always_comb begin
    dp = '0;
    for (int i = 0; i < N; i++) begin
      dp = dp + ACC_WIDTH'(prod[i]);
    end
  end

endmodule

// File: rtl/neuron_datapath.sv
// Single-neuron cell: dot product + bias, shift/saturate, ReLU, registered output.
module neuron_datapath
  import npu_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = npu_pkg::DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = npu_pkg::ACC_WIDTH,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] x [N],
  input  logic signed [DATA_WIDTH-1:0] w [N],
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int unsigned MIN_ACC = 2 * DATA_WIDTH + $clog2(N) + 1;

  if (N < 1) begin : g_bad_n
    $error("neuron_datapath: N must be at least 1");
  end
  if (ACC_WIDTH < MIN_ACC) begin : g_bad_acc
    $error("neuron_datapath: ACC_WIDTH too narrow for N and DATA_WIDTH");
  end
  if (ACC_WIDTH > WIDE_WIDTH) begin : g_bad_wide
    $error("neuron_datapath: ACC_WIDTH exceeds quantizer width");
  end
  if (SHIFT >= ACC_WIDTH) begin : g_bad_shift
    $error("neuron_datapath: SHIFT must be below ACC_WIDTH");
  end

  logic signed [ACC_WIDTH-1:0]  dp;
  logic signed [ACC_WIDTH-1:0]  sum;
  wide_t                        act;
  logic signed [DATA_WIDTH-1:0] relu_out;

  mac_tree #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac_tree (
    .x  (x),
    .w  (w),
    .dp (dp)
  );

  // Bias add, fixed-point rescale with saturation, then activation.
  always_comb begin
    sum      = dp + ACC_WIDTH'(b);
    act      = relu(sat_shift(WIDE_WIDTH'(sum), SHIFT, DATA_WIDTH));
    relu_out = DATA_WIDTH'(act);
  end

  // Output register: capture on valid, hold otherwise; reset drops in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y <= relu_out;
    end
  end

endmodule

// File: tb/tb_neuron_datapath.sv
// Self-checking bench for neuron_datapath (SHIFT=0 and SHIFT=4 instances).
module tb_neuron_datapath;
  import npu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] x [4];
  logic signed [7:0] w [4];
  logic signed [7:0] b;
  logic              v0, v4;
  logic signed [7:0] y0, y4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic signed [7:0] exp_y0, exp_y4;
  logic              exp_v;

  always #5 clk = ~clk;

  neuron_datapath #(.N(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .w(w), .b(b),
    .out_valid(v0), .y(y0)
  );

  neuron_datapath #(.N(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .w(w), .b(b),
    .out_valid(v4), .y(y4)
  );

  // Reference: plain integer dot product, floor shift, clamp, rectify.
  function automatic logic signed [7:0] ref_out(input int sh);
    longint s;
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'(x[i]) * longint'(w[i]);
    s += longint'(b);
    s = s >>> sh;
    if (s > longint'(DATA_MAX)) s = longint'(DATA_MAX);
    if (s < longint'(DATA_MIN)) s = longint'(DATA_MIN);
    if (s < 0) s = 0;
    return 8'(s);
  endfunction

  task automatic check(input string tag, input logic signed [7:0] obs,
                       input logic signed [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    8'(v0), 8'(exp_v));
    check({tag, ".y"},        y0,     exp_y0);
    check({tag, ".valid_s4"}, 8'(v4), 8'(exp_v));
    check({tag, ".y_s4"},     y4,     exp_y4);
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                         input int c0, input int c1, input int c2, input int c3,
                         input int bb);
    x[0] = 8'(a0); x[1] = 8'(a1); x[2] = 8'(a2); x[3] = 8'(a3);
    w[0] = 8'(c0); w[1] = 8'(c1); w[2] = 8'(c2); w[3] = 8'(c3);
    b    = 8'(bb);
  endtask

  // Called in the low phase: predict, clock once, sample 1 time unit after the edge.
  task automatic step(input string tag);
    logic signed [7:0] n0, n4;
    logic              iv;
    n0 = ref_out(0);
    n4 = ref_out(4);
    iv = in_valid;
    @(posedge clk);
    #1;
    if (iv) begin
      exp_y0 = n0;
      exp_y4 = n4;
    end
    exp_v = iv;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic run_vec(input string tag,
                         input int a0, input int a1, input int a2, input int a3,
                         input int c0, input int c1, input int c2, input int c3,
                         input int bb);
    set_vec(a0, a1, a2, a3, c0, c1, c2, c3, bb);
    in_valid = 1'b1;
    step(tag);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_y0 = '0; exp_y4 = '0; exp_v = 1'b0;

    // Power-on reset, applied before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_release_idle");

    // Basic and hold.
    run_vec("basic", 1, 2, 3, 4, 1, 1, 1, 1, 5);
    in_valid = 1'b0;
    step("basic_hold");

    // Asynchronous reset mid-cycle with y=15 held.
    #2 rst_n = 1'b0;
    #1;
    exp_y0 = '0; exp_y4 = '0; exp_v = 1'b0;
    check_all("reset_mid_cycle");
    set_vec(1, 2, 3, 4, 1, 1, 1, 1, 5);
    in_valid = 1'b1;
    @(posedge clk);
    #1 check_all("reset_edge_discard");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step("reset_release_hold");

    // Directed cases.
    run_vec("neg_clamp",   1, 2, 3, 4, -1, -1, -1, -1, 0);
    run_vec("exact_zero",  1, -1, 0, 0, 1, 1, 0, 0, 0);
    run_vec("sat_pos",     127, 127, 127, 127, 127, 127, 127, 127, 127);
    run_vec("sat_negneg",  -128, -128, -128, -128, -128, -128, -128, -128, -128);
    run_vec("max_exact",   127, 0, 0, 0, 1, 0, 0, 0, 0);
    run_vec("max_plus1",   127, 0, 0, 0, 1, 0, 0, 0, 1);
    run_vec("bias_minus1", 100, 0, 0, 0, 1, 0, 0, 0, -1);
    run_vec("shift_100",   10, 0, 0, 0, 10, 0, 0, 0, 0);
    run_vec("neg_sat_min", -128, 127, 0, 0, 127, 127, 0, 0, -128);

    // Randomized streaming with occasional bubbles.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        x[i] = 8'($urandom_range(0, 255));
        w[i] = 8'($urandom_range(0, 255));
      end
      b        = 8'($urandom_range(0, 255));
      in_valid = ($urandom_range(0, 3) != 0);
      step("random");
    end

    in_valid = 1'b0;
    step("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_datapath.md
Name: neuron_datapath

Overview:
- Single-neuron compute datapath for the NPU: signed dot product of an N-element input vector and weight vector, plus bias, quantized to data width, ReLU-activated.
- Output is registered: one result per clock, one-cycle latency.
- Built from the same dot-product, quantize and activate stages the perceptron layer uses.
- Intended as the leaf compute cell replicated across a layer.

Parameters:
- N, 4, vector length (N >= 1).
- DATA_WIDTH, 8, signed width of x, w, b, y.
- ACC_WIDTH, 32, signed accumulator width. Elaboration error unless ACC_WIDTH >= 2*DATA_WIDTH + $clog2(N) + 1.
- SHIFT, 0, arithmetic right shift applied before saturation (fixed-point rescale). Must satisfy 0 <= SHIFT < ACC_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active low.
- in_valid  input  1  x/w/b valid this cycle.
- x  input  N x DATA_WIDTH signed  input vector (unpacked array [N]).
- w  input  N x DATA_WIDTH signed  weight vector (unpacked array [N]).
- b  input  DATA_WIDTH signed  bias.
- out_valid  output  1  y holds a new result.
- y  output  DATA_WIDTH signed  activated result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n = 0, y = 0 and out_valid = 0 immediately, with no clock required. First capture happens on the first rising edge after deassertion.
- Stage 1 (combinational): each product x[i]*w[i] is a full-precision signed 2*DATA_WIDTH product, sign-extended to ACC_WIDTH. The products are summed into dp. Overflow is impossible by the width rule.
- Stage 2: sum = dp + sign-extended b, at ACC_WIDTH.
- Quantize:
  - s = sum >>> SHIFT (arithmetic, floor toward -inf).
  - If s > 2^(DATA_WIDTH-1)-1, output the max positive value.
  - If s < -2^(DATA_WIDTH-1), output the min negative value.
  - Otherwise output the low DATA_WIDTH bits of s.
- ReLU: out = (pre < 0) ? 0 : pre. A zero input gives 0.
- Register:
  - On each rising clk, y <= relu_out when in_valid = 1; y holds when in_valid = 0.
  - out_valid <= in_valid.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle.
- No backpressure; no ready signal.
- Reset asserted mid-stream: the in-flight result is discarded. y = 0 and out_valid = 0 until a new in_valid is clocked after release.
- No simulation-only $display in synthesizable code.

Decomposition:
- Shared package npu_pkg:
  - DATA_WIDTH and ACC_WIDTH defaults.
  - data_t (logic signed [DATA_WIDTH-1:0]) and acc_t (logic signed [ACC_WIDTH-1:0]) typedefs.
  - Localparams DATA_MAX and DATA_MIN.
- One natural sub-module: mac_tree, the combinational N-way multiply and adder tree producing dp.
- Quantize and ReLU stay inline as functions in the package: sat_shift() and relu().

Test Plan (N=4, DATA_WIDTH=8, ACC_WIDTH=32, SHIFT=0 unless noted):
- Reset: assert rst_n=0 asynchronously mid-cycle with prior y=15 -> y=0 and out_valid=0 immediately, without waiting for a clk edge. Both stay 0 after release until in_valid is clocked.
- Basic: x={1,2,3,4}, w={1,1,1,1}, b=5, in_valid=1 -> after 1 edge y=15, out_valid=1. Next cycle in_valid=0 -> out_valid=0, y stays 15.
- Negative clamp: x={1,2,3,4}, w={-1,-1,-1,-1}, b=0 -> y=0. Exact zero: x={1,-1,0,0}, w={1,1,0,0}, b=0 -> y=0.
- Positive saturation: x all 127, w all 127, b=127 (sum 64643) -> y=127. x all -128, w all -128, b=-128 (sum 65408) -> y=127.
- Boundary: x={127,0,0,0}, w={1,0,0,0}, b=0 -> y=127. Same with b=1 -> y=127 (saturate). x={100,0,0,0}, w={1,0,0,0}, b=-1 -> y=99.
- Shift and streaming: SHIFT=4 build, x={10,0,0,0}, w={10,0,0,0}, b=0 (sum 100) -> y=6. Back-to-back vectors on consecutive cycles -> each result appears exactly one cycle later, with none dropped.
